// File: rtl/input_collector.sv
// ---------------------------------------------------------------------------
// input_collector
//   Feeds stage 1 of the pipelined 8-input adder tree. Serial operand bytes
//   are gathered into a shadow frame. The whole frame is published on in0..in7
//   at once, and frame_valid pulses for one cycle on that publish.
//   Frames start on din_sof. A partial frame is aborted by a new SOF or by
//   FRAME_TIMEOUT idle cycles. Outputs only change on a publish edge.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   din          serial operand byte
//   din_valid    din is valid this cycle
//   din_sof      din is slot 0 of a new frame (only with din_valid)
//   in0..in7     published frame operands (registered)
//   frame_valid  1-cycle pulse, in0..in7 just took a new frame
//   busy         high while a partial frame is being collected
//   err_abort    1-cycle pulse, byte dropped or partial frame discarded
//   frame_count  published frames, wraps 255->0
// ---------------------------------------------------------------------------
module input_collector #(
  parameter int WIDTH         = 8,
  parameter int FRAME_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             din_sof,
  output logic [WIDTH-1:0] in0,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] in4,
  output logic [WIDTH-1:0] in5,
  output logic [WIDTH-1:0] in6,
  output logic [WIDTH-1:0] in7,
  output logic             frame_valid,
  output logic             busy,
  output logic             err_abort,
  output logic [7:0]       frame_count
);

  localparam int TW = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t           state;
  logic [2:0]       idx;
  logic [TW-1:0]    tcnt;
  // Slot 7 is never stored: byte 7 goes straight to in7 on the publish edge.
  logic [WIDTH-1:0] shadow [0:7];

  // Frame collector FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      tcnt        <= '0;
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
      in0         <= '0;
      in1         <= '0;
      in2         <= '0;
      in3         <= '0;
      in4         <= '0;
      in5         <= '0;
      in6         <= '0;
      in7         <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      err_abort   <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_valid <= 1'b0;
      err_abort   <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid) begin
            if (din_sof) begin
              shadow[0] <= din;
              idx       <= 3'd1;
              tcnt      <= '0;
              state     <= COLLECT;
              busy      <= 1'b1;
            end else begin
              // Stray byte outside a frame
              err_abort <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (din_valid) begin
            tcnt <= '0;
            if (din_sof) begin
              // Re-sync: drop the partial frame, this byte starts a new one
              err_abort <= 1'b1;
              shadow[0] <= din;
              idx       <= 3'd1;
            end else if (idx == 3'd7) begin
              in0         <= shadow[0];
              in1         <= shadow[1];
              in2         <= shadow[2];
              in3         <= shadow[3];
              in4         <= shadow[4];
              in5         <= shadow[5];
              in6         <= shadow[6];
              in7         <= din;
              frame_valid <= 1'b1;
              frame_count <= frame_count + 8'd1;
              idx         <= 3'd0;
              state       <= IDLE;
              busy        <= 1'b0;
            end else begin
              shadow[idx] <= din;
              idx         <= idx + 3'd1;
            end
          end else if (tcnt == TW'(FRAME_TIMEOUT - 1)) begin
            // This idle cycle brings the count to FRAME_TIMEOUT
            err_abort <= 1'b1;
            tcnt      <= '0;
            idx       <= 3'd0;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= 3'd0;
          tcnt  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_collector.sv
// ---------------------------------------------------------------------------
// tb_input_collector
//   Directed bench for input_collector. Each driven beat is checked one step
//   after the clock edge. Complete frames are pushed to a scoreboard queue
//   when they are sent, and popped when frame_valid is seen.
// ---------------------------------------------------------------------------
module tb_input_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_sof;
  logic [7:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic       frame_valid;
  logic       busy;
  logic       err_abort;
  logic [7:0] frame_count;

  int passed = 0;
  int total  = 0;

  logic [63:0] exp_q [$];
  logic [63:0] last_frame = 64'd0;
  logic [7:0]  fc_exp     = 8'd0;

  input_collector #(.WIDTH(8), .FRAME_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .in6(in6), .in7(in7), .frame_valid(frame_valid), .busy(busy),
    .err_abort(err_abort), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one beat, wait for the edge, then check the outputs it produced.
  task automatic step(input logic v, input logic s, input logic [7:0] d,
                      input logic exp_fv, input logic exp_err, input logic exp_busy);
    logic [63:0] bus;
    logic [63:0] want;
    din_valid = v;
    din_sof   = s;
    din       = d;
    @(posedge clk);
    #1;
    bus = {in0, in1, in2, in3, in4, in5, in6, in7};
    chk("frame_valid", {63'd0, frame_valid}, {63'd0, exp_fv});
    chk("err_abort",   {63'd0, err_abort},   {63'd0, exp_err});
    chk("busy",        {63'd0, busy},        {63'd0, exp_busy});
    chk("frame_count", {56'd0, frame_count}, {56'd0, fc_exp});
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 64'd1, 64'd0);
      end else begin
        want       = exp_q.pop_front();
        last_frame = want;
        chk("frame_data", bus, want);
      end
    end else begin
      chk("hold_data", bus, last_frame);
    end
  endtask

  // Send a full 8-byte frame, f[63:56] is slot 0; first_err if SOF aborts a partial frame.
  task automatic send_frame(input logic [63:0] f, input logic first_err);
    exp_q.push_back(f);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) fc_exp = fc_exp + 8'd1;
      step(1'b1, i == 0, f[63 - 8*i -: 8], i == 7, (i == 0) && first_err, i != 7);
    end
  endtask

  initial begin
    // 1 Reset with din_valid high
    rst = 1'b1;
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 2 Basic frame 1..8
    send_frame(64'h0102030405060708, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 3 Re-sync: SOF + 3 bytes, then a full frame whose SOF aborts it
    step(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'hA3, 1'b0, 1'b0, 1'b1);
    send_frame(64'h1011121314151617, 1'b1);

    // 4 Timeout: SOF + 4 bytes, then 16 idle cycles
    step(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) step(1'b0, 1'b0, 8'h00, 1'b0, k == 16, k < 16);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 5 Stray data while IDLE
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(64'h2122232425262728, 1'b0);

    // Reset mid-frame: silent discard, everything cleared
    step(1'b1, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'hD1, 1'b0, 1'b0, 1'b1);
    rst        = 1'b1;
    fc_exp     = 8'd0;
    last_frame = 64'd0;
    step(1'b1, 1'b0, 8'hD2, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 6 Wrap: 256 back-to-back frames of 0xFF
    for (int n = 0; n < 256; n++) send_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("wrap_count_zero", {56'd0, frame_count}, 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
